ddma_send_scheduler: RTL

//  Queues DMA send descriptors (dest, addr, size) that the CPU writes through MMIO.

---
 rtl/ddma_send_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ddma_send_scheduler.sv
// ddma_send_scheduler
//   Buffers DMA send descriptors written by the CPU over MMIO. It issues them one at a
//   time to the DDMA send port and runs the cmd / irq_send handshake, so software does
//   not have to poll the send state. Completions are counted and raised as a sticky IRQ.
//
// Ports
//   clock, reset            rising-edge clock; asynchronous active-low reset
//   push_*_in               descriptor enqueue (valid, dest, addr, size)
//   push_ready_out          queue not full
//   flush_in                drop every queued descriptor; the in-flight one is kept
//   ddma_*_out              descriptor and cmd driven to the DDMA send port
//   ddma_irq_in             DDMA transfer-finished strobe
//   level_out               queued entries; the in-flight descriptor is not counted
//   busy_out                a descriptor is in flight or being released
//   done_count_out          completed transfers (wraps)
//   irq_done_out            sticky completion flag, cleared by irq_ack_in
//   irq_ack_in              clears irq_done_out and err_timeout_out
//   err_timeout_out         sticky flag: a transfer was aborted by timeout
module ddma_send_scheduler #(
    parameter int unsigned MEMORY_WIDTH   = 32,
    parameter int unsigned QUEUE_DEPTH    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push_valid_in,
    input  logic [MEMORY_WIDTH-1:0]       push_dest_in,
    input  logic [MEMORY_WIDTH-1:0]       push_addr_in,
    input  logic [MEMORY_WIDTH-1:0]       push_size_in,
    output logic                          push_ready_out,
    input  logic                          flush_in,
    output logic [MEMORY_WIDTH-1:0]       ddma_dest_out,
    output logic [MEMORY_WIDTH-1:0]       ddma_addr_out,
    output logic [MEMORY_WIDTH-1:0]       ddma_size_out,
    output logic                          ddma_cmd_out,
    input  logic                          ddma_irq_in,
    output logic [$clog2(QUEUE_DEPTH):0]  level_out,
    output logic                          busy_out,
    output logic [MEMORY_WIDTH-1:0]       done_count_out,
    output logic                          irq_done_out,
    input  logic                          irq_ack_in,
    output logic                          err_timeout_out
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StRelease} state_e;

    state_e                  state_q;
    logic [MEMORY_WIDTH-1:0] mem_dest_q [QUEUE_DEPTH];
    logic [MEMORY_WIDTH-1:0] mem_addr_q [QUEUE_DEPTH];
    logic [MEMORY_WIDTH-1:0] mem_size_q [QUEUE_DEPTH];
    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]         count_q, count_d;
    logic [31:0]             tmo_q;

    logic full, empty, push_acc, pop, timeout_hit, set_done, set_err;

    assign full     = (count_q == CntW'(QUEUE_DEPTH));
    assign empty    = (count_q == '0);
    // A full queue drops the push even when a pop happens on the same edge.
    assign push_acc = push_valid_in && !full && !flush_in;
    // Flush also blocks the issue of a head entry on that edge.
    assign pop      = (state_q == StIdle) && !empty && !flush_in;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TIMEOUT_CYCLES - 32'd1);
    assign set_done    = (state_q == StIssue) && ddma_irq_in;
    assign set_err     = (state_q == StIssue) && !ddma_irq_in && timeout_hit;

    assign push_ready_out = !full;
    assign level_out      = count_q;

    always_comb begin
        count_d = count_q;
        if (push_acc && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_acc && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Descriptor storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push_acc) begin
            mem_dest_q[wr_ptr_q] <= push_dest_in;
            mem_addr_q[wr_ptr_q] <= push_addr_in;
            mem_size_q[wr_ptr_q] <= push_size_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            ddma_dest_out   <= '0;
            ddma_addr_out   <= '0;
            ddma_size_out   <= '0;
            ddma_cmd_out    <= 1'b0;
            busy_out        <= 1'b0;
            done_count_out  <= '0;
            irq_done_out    <= 1'b0;
            err_timeout_out <= 1'b0;
            tmo_q           <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        ddma_dest_out <= mem_dest_q[rd_ptr_q];
                        ddma_addr_out <= mem_addr_q[rd_ptr_q];
                        ddma_size_out <= mem_size_q[rd_ptr_q];
                        ddma_cmd_out  <= 1'b1;
                        busy_out      <= 1'b1;
                        tmo_q         <= '0;
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    // A completion seen on the timeout edge still counts as a completion.
                    if (ddma_irq_in) begin
                        ddma_cmd_out   <= 1'b0;
                        done_count_out <= done_count_out + 1'b1;
                        state_q        <= StRelease;
                    end else if (timeout_hit) begin
                        ddma_cmd_out <= 1'b0;
                        state_q      <= StRelease;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                StRelease: begin
                    if (!ddma_irq_in) begin
                        busy_out <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    ddma_cmd_out <= 1'b0;
                    busy_out     <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase

            // Sticky flags: a set on the same edge as an ack wins.
            if (set_done) begin
                irq_done_out <= 1'b1;
            end else if (irq_ack_in) begin
                irq_done_out <= 1'b0;
            end
            if (set_err) begin
                err_timeout_out <= 1'b1;
            end else if (irq_ack_in) begin
                err_timeout_out <= 1'b0;
            end
        end
    end

endmodule
